// File: rtl/jump_ctrl_pkg.sv
// Shared types and constants for the jump sequencing controller.
package jump_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RS1_WAIT = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } jump_state_e;

  typedef logic [3:0] flush_cnt_t;

  localparam logic [31:0] LINK_OFFSET = 32'd4;

endpackage

// File: rtl/jump_target_calc.sv
// Combinational jump target: JAL is pc-relative with a 21-bit offset,
// JALR is register-relative with a 12-bit offset and bit0 cleared.
module jump_target_calc (
  input  logic [31:0] base,
  input  logic [20:0] imm,
  input  logic        is_jalr,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] sext_j;
  logic [31:0] sext_i;
  logic [31:0] sum;

  always_comb begin
    sext_j     = {{11{imm[20]}}, imm};
    sext_i     = {{20{imm[11]}}, imm[11:0]};
    sum        = base + (is_jalr ? sext_i : sext_j);
    target     = is_jalr ? (sum & ~32'h1) : sum;
    misaligned = target[1];
  end

endmodule

// File: rtl/jump_ctrl_fsm.sv
// Jump sequencing controller: rs1 fetch for JALR, redirect handshake,
// link writeback and flush window. Optional JUMP_MISALIGN_TRAP_EN traps bit1 targets.
`ifndef JMP_NOP
`define JMP_NOP 2'b00
`define JAL     2'b01
`define JALR    2'b10
`endif

module jump_ctrl_fsm
  import jump_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_valid,
  input  logic [1:0]  jump_control,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [20:0] imm,
  input  logic [31:0] pc,
  output logic        rf_rd_req,
  output logic [4:0]  rf_rd_addr,
  input  logic        rf_rd_valid,
  input  logic [31:0] rf_rd_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        flush,
  output logic        stall,
  output logic        misalign_exc
);

  localparam flush_cnt_t FLUSH_LOAD = flush_cnt_t'(FLUSH_CYCLES - 1);

  jump_state_e state_q, state_d;
  flush_cnt_t  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [20:0] imm_q, imm_d;
  logic        rf_rd_req_q, rf_rd_req_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        flush_q, flush_d;
  logic        stall_q, stall_d;
  logic        misalign_q, misalign_d;

  logic [31:0] calc_base;
  logic [20:0] calc_imm;
  logic        calc_jalr;
  logic [31:0] target;
  logic        misaligned;
  logic        trap;

  // In IDLE the target comes straight from decode so JAL redirects next cycle.
  always_comb begin
    calc_jalr = (state_q == RS1_WAIT);
    calc_base = calc_jalr ? rf_rd_data : pc;
    calc_imm  = calc_jalr ? imm_q      : imm;
  end

  jump_target_calc u_calc (
    .base       (calc_base),
    .imm        (calc_imm),
    .is_jalr    (calc_jalr),
    .target     (target),
    .misaligned (misaligned)
  );

`ifdef JUMP_MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    pc_d             = pc_q;
    rd_d             = rd_q;
    rs1_d            = rs1_q;
    imm_d            = imm_q;
    rf_rd_req_d      = 1'b0;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    wb_valid_d       = 1'b0;
    wb_rd_d          = wb_rd_q;
    wb_data_d        = wb_data_q;
    flush_d          = 1'b0;
    misalign_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (jump_valid && jump_control != `JMP_NOP) begin
          pc_d  = pc;
          rd_d  = rd;
          rs1_d = rs1;
          imm_d = imm;
          if (jump_control == `JALR) begin
            state_d     = RS1_WAIT;
            rf_rd_req_d = 1'b1;
          end else if (trap) begin
            state_d    = FLUSH;
            misalign_d = 1'b1;
            flush_d    = 1'b1;
            cnt_d      = FLUSH_LOAD;
          end else begin
            state_d          = REDIRECT;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
          end
        end
      end
      RS1_WAIT: begin
        if (rf_rd_valid) begin
          if (trap) begin
            state_d    = FLUSH;
            misalign_d = 1'b1;
            flush_d    = 1'b1;
            cnt_d      = FLUSH_LOAD;
          end else begin
            state_d          = REDIRECT;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d          = FLUSH;
          redirect_valid_d = 1'b0;
          wb_valid_d       = (rd_q != 5'd0);
          wb_rd_d          = rd_q;
          wb_data_d        = pc_q + LINK_OFFSET;
          flush_d          = 1'b1;
          cnt_d            = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (cnt_q != '0) begin
          flush_d = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      pc_q             <= '0;
      rd_q             <= '0;
      rs1_q            <= '0;
      imm_q            <= '0;
      rf_rd_req_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      misalign_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      pc_q             <= pc_d;
      rd_q             <= rd_d;
      rs1_q            <= rs1_d;
      imm_q            <= imm_d;
      rf_rd_req_q      <= rf_rd_req_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      wb_valid_q       <= wb_valid_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      flush_q          <= flush_d;
      stall_q          <= stall_d;
      misalign_q       <= misalign_d;
    end
  end

  assign rf_rd_req      = rf_rd_req_q;
  assign rf_rd_addr     = rs1_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign flush          = flush_q;
  assign stall          = stall_q;
`ifdef JUMP_MISALIGN_TRAP_EN
  assign misalign_exc   = misalign_q;
`else
  assign misalign_exc   = 1'b0;
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_jump_ctrl_fsm.sv
// Directed self-checking bench for jump_ctrl_fsm (FLUSH_CYCLES = 2).
module tb_jump_ctrl_fsm;

  localparam logic [1:0] E_NOP  = 2'b00;
  localparam logic [1:0] E_JAL  = 2'b01;
  localparam logic [1:0] E_JALR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_valid;
  logic [1:0]  jump_control;
  logic [4:0]  rd, rs1;
  logic [20:0] imm;
  logic [31:0] pc;
  logic        rf_rd_req;
  logic [4:0]  rf_rd_addr;
  logic        rf_rd_valid;
  logic [31:0] rf_rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, stall, misalign_exc;

  int n_chk = 0;
  int n_err = 0;
  int wb_cnt;

  jump_ctrl_fsm #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .jump_valid(jump_valid), .jump_control(jump_control),
    .rd(rd), .rs1(rs1), .imm(imm), .pc(pc),
    .rf_rd_req(rf_rd_req), .rf_rd_addr(rf_rd_addr),
    .rf_rd_valid(rf_rd_valid), .rf_rd_data(rf_rd_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall(stall), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] ctl, input logic [31:0] p,
                       input logic [20:0] im, input logic [4:0] d, input logic [4:0] s);
    jump_valid = 1'b1; jump_control = ctl; pc = p; imm = im; rd = d; rs1 = s;
    tick();
    jump_valid = 1'b0; jump_control = E_NOP;
  endtask

  initial begin
    rst = 1'b1; jump_valid = 0; jump_control = E_NOP; rd = 0; rs1 = 0; imm = 0; pc = 0;
    rf_rd_valid = 0; rf_rd_data = 0; redirect_ready = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_rv", {31'd0, redirect_valid}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    rst = 1'b0;
    tick();

    // NOP with valid is not a jump
    jump_valid = 1; jump_control = E_NOP; tick(); jump_valid = 0;
    chk("nop_stall", {31'd0, stall}, 0);

    // JAL pc=0x100 imm=0x20 rd=1, fetch already ready
    redirect_ready = 1;
    issue(E_JAL, 32'h100, 21'h20, 5'd1, 5'd0);
    chk("jal_rv", {31'd0, redirect_valid}, 1);
    chk("jal_pc", redirect_pc, 32'h120);
    chk("jal_stall", {31'd0, stall}, 1);
    tick();
    chk("jal_wbv", {31'd0, wb_valid}, 1);
    chk("jal_wbrd", {27'd0, wb_rd}, 1);
    chk("jal_wbdata", wb_data, 32'h104);
    chk("jal_flush1", {31'd0, flush}, 1);
    chk("jal_rv_drop", {31'd0, redirect_valid}, 0);
    tick();
    chk("jal_flush2", {31'd0, flush}, 1);
    chk("jal_wb_pulse", {31'd0, wb_valid}, 0);
    tick();
    chk("jal_flush_end", {31'd0, flush}, 0);
    chk("jal_idle", {31'd0, stall}, 0);
    redirect_ready = 0;

    // JALR rs1=5 imm=0xFFF, data 0x2003 a few cycles later
    issue(E_JALR, 32'h200, 21'h000FFF, 5'd2, 5'd5);
    chk("jalr_req", {31'd0, rf_rd_req}, 1);
    chk("jalr_addr", {27'd0, rf_rd_addr}, 5);
    // a new jump during RS1_WAIT must be ignored
    jump_valid = 1; jump_control = E_JAL; pc = 32'h900; imm = 21'h4;
    tick();
    jump_valid = 0; jump_control = E_NOP;
    chk("jalr_req_pulse", {31'd0, rf_rd_req}, 0);
    chk("jalr_wait_rv", {31'd0, redirect_valid}, 0);
    tick();
    rf_rd_valid = 1; rf_rd_data = 32'h2003;
    tick();
    rf_rd_valid = 0; rf_rd_data = 0;
    chk("jalr_rv", {31'd0, redirect_valid}, 1);
    chk("jalr_pc", redirect_pc, 32'h2002);
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
    chk("jalr_wbv", {31'd0, wb_valid}, 1);
    chk("jalr_wbrd", {27'd0, wb_rd}, 2);
    chk("jalr_wbdata", wb_data, 32'h204);
    tick(); tick();
    chk("jalr_idle", {31'd0, stall}, 0);

    // rf_rd_valid while idle is ignored
    rf_rd_valid = 1; rf_rd_data = 32'h5000; tick(); rf_rd_valid = 0;
    chk("stray_rf_rv", {31'd0, redirect_valid}, 0);

    // JAL backpressured for 4 cycles, negative offset
    wb_cnt = 0;
    issue(E_JAL, 32'h300, 21'h1FFFF0, 5'd3, 5'd0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_rv", {31'd0, redirect_valid}, 1);
      chk("bp_pc", redirect_pc, 32'h2F0);
      chk("bp_stall", {31'd0, stall}, 1);
      if (wb_valid) wb_cnt++;
      tick();
    end
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid) wb_cnt++;
      tick();
    end
    chk("bp_wb_once", wb_cnt, 1);
    chk("bp_idle", {31'd0, stall}, 0);

    // rd=0 with wrapping pc
    wb_cnt = 0;
    redirect_ready = 1;
    issue(E_JAL, 32'hFFFFFFFC, 21'h8, 5'd0, 5'd0);
    chk("wrap_pc", redirect_pc, 32'h4);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) chk("wrap_wbdata_next", {31'd0, redirect_valid}, 1);
      tick();
      if (wb_valid) wb_cnt++;
      if (i == 0) chk("wrap_wbdata", wb_data, 32'h0);
    end
    redirect_ready = 0;
    chk("rd0_no_wb", wb_cnt, 0);

    // reset while waiting for rs1
    issue(E_JALR, 32'h400, 21'h10, 5'd4, 5'd7);
    tick();
    chk("rw_addr_pre", {27'd0, rf_rd_addr}, 7);
    #1 rst = 1'b1;
    #1;
    chk("rr_stall", {31'd0, stall}, 0);
    chk("rr_addr", {27'd0, rf_rd_addr}, 0);
    chk("rr_req", {31'd0, rf_rd_req}, 0);
    @(negedge clk);
    rst = 1'b0;
    rf_rd_valid = 1; rf_rd_data = 32'h8000;
    tick(); tick();
    rf_rd_valid = 0;
    chk("rr_no_rv", {31'd0, redirect_valid}, 0);
    chk("rr_no_stall", {31'd0, stall}, 0);
    chk("rr_no_wb", {31'd0, wb_valid}, 0);

`ifdef JUMP_MISALIGN_TRAP_EN
    redirect_ready = 1;
    issue(E_JAL, 32'h100, 21'h2, 5'd1, 5'd0);
    chk("mis_exc", {31'd0, misalign_exc}, 1);
    chk("mis_rv", {31'd0, redirect_valid}, 0);
    chk("mis_flush", {31'd0, flush}, 1);
    tick();
    chk("mis_exc_pulse", {31'd0, misalign_exc}, 0);
    chk("mis_wb", {31'd0, wb_valid}, 0);
    tick(); tick();
    chk("mis_idle", {31'd0, stall}, 0);
    redirect_ready = 0;
`else
    issue(E_JAL, 32'h100, 21'h2, 5'd1, 5'd0);
    chk("nomis_exc", {31'd0, misalign_exc}, 0);
    chk("nomis_pc", redirect_pc, 32'h102);
    redirect_ready = 1;
    tick(); tick(); tick();
    redirect_ready = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
